oam_dma: RTL and testbench

Sprite-DMA engine for the 2A03. It sits on the CPU side of the system bus, directly downstream of `cpu_2a03`. It snoops CPU writes to $4014 and then halts the CPU through `cpu_rdy`. While the CPU is halted, it owns the bus and copies 256 bytes from page `$XX00–$XXFF` to the PPU OAM data port. Ownership of the bus is signalled by `dma_owns_bus`, which drives the top-level address, data and rw muxes.

---
 rtl/oam_dma.sv | 102 ++++++++++
 tb/tb_oam_dma.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops CPU writes to the trigger address, halts the CPU
// and copies one 256-byte page to the OAM data port as alternating read/write pairs.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic        dma_owns_bus,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_wdata
);

  // state  | meaning
  // IDLE   | CPU runs, watching for a trigger write
  // HALT   | cpu_rdy low, waiting for the CPU to reach a read (halt) cycle
  // ALIGN  | one dummy cycle so the first READ lands on an even cycle
  // READ   | DMA reads {page, idx} (even cycle)
  // WRITE  | DMA writes the latched byte to the OAM data port (odd cycle)
  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state, state_nx;
  logic [7:0] page, page_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] rd_buf;
  logic       phase;

  always_comb begin
    state_nx = state;
    page_nx  = page;
    idx_nx   = idx;
    case (state)
      S_IDLE: begin
        if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
          page_nx  = cpu_wdata;
          idx_nx   = 8'h00;
          state_nx = S_HALT;
        end
      end
      S_HALT: begin
        // phase=1 now means the following cycle is even, so READ can start there
        if (cpu_rw) state_nx = phase ? S_READ : S_ALIGN;
      end
      S_ALIGN: state_nx = S_READ;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: begin
        if (idx == 8'hFF) begin
          state_nx = S_IDLE;
        end else begin
          idx_nx   = idx + 8'h01;
          state_nx = S_READ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they only move on the clock edge
  always_ff @(posedge clock) begin
    if (nreset) begin
      state        <= S_IDLE;
      page         <= 8'h00;
      idx          <= 8'h00;
      rd_buf       <= 8'h00;
      phase        <= 1'b0;
      cpu_rdy      <= 1'b1;
      dma_owns_bus <= 1'b0;
      dma_rw       <= 1'b1;
      dma_addr     <= 16'h0000;
    end else begin
      state        <= state_nx;
      page         <= page_nx;
      idx          <= idx_nx;
      phase        <= ~phase;
      cpu_rdy      <= (state_nx == S_IDLE);
      dma_owns_bus <= (state_nx == S_READ) || (state_nx == S_WRITE);
      if (state == S_READ) rd_buf <= bus_rdata;
      if (state_nx == S_READ) begin
        dma_rw   <= 1'b1;
        dma_addr <= {page_nx, idx_nx};
      end else if (state_nx == S_WRITE) begin
        dma_rw   <= 1'b0;
        dma_addr <= DEST_ADDR;
      end
    end
  end

  assign dma_wdata = rd_buf;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random source memory, randomized transfers,
// checked against a page-copy model with even/odd stall arithmetic.
module tb_oam_dma;

  logic        clock;
  logic        nreset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_owns_bus;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];
  int cyc = 0;

  int          log_cyc [$];
  logic        log_rw [$];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  int stall_cnt;
  int first_rd;
  int trig_cyc;
  bit timeout;

  oam_dma dut (
    .clock        (clock),
    .nreset       (nreset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rw       (cpu_rw),
    .bus_rdata    (bus_rdata),
    .cpu_rdy      (cpu_rdy),
    .dma_owns_bus (dma_owns_bus),
    .dma_addr     (dma_addr),
    .dma_rw       (dma_rw),
    .dma_wdata    (dma_wdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle index since reset; even index <=> DMA phase 0
  always @(posedge clock) begin
    if (nreset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  assign bus_rdata = (dma_owns_bus && dma_rw) ? mem[dma_addr] : 8'h5A;

  task automatic drive_idle();
    cpu_rw    = 1'b1;
    cpu_addr  = 16'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock);
    nreset = 1'b1;
    drive_idle();
    repeat (n) @(negedge clock);
    nreset = 1'b0;
  endtask

  // Triggers a transfer timed so the halt cycle has the requested parity,
  // then logs every DMA bus cycle until the CPU is released.
  task automatic run_transfer(input logic [7:0] pg, input int w, input bit halt_even,
                              input bit trig_in_write);
    int k;
    bit done;
    bit trig_sent;
    log_cyc.delete(); log_rw.delete(); log_addr.delete(); log_data.delete();
    stall_cnt = 0; first_rd = -1; timeout = 0;
    @(negedge clock);
    while (((cyc + 1 + w) % 2) != (halt_even ? 0 : 1)) begin
      drive_idle();
      @(negedge clock);
    end
    cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = pg;
    trig_cyc = cyc;
    k = 0; done = 0; trig_sent = 0;
    while (!done && k < 800) begin
      @(negedge clock);
      k++;
      if (!cpu_rdy) stall_cnt++;
      else done = 1;
      if (dma_owns_bus) begin
        log_cyc.push_back(cyc);
        log_rw.push_back(dma_rw);
        log_addr.push_back(dma_addr);
        log_data.push_back(dma_wdata);
        if (first_rd < 0 && dma_rw) first_rd = cyc;
      end
      if (k <= w) begin
        cpu_rw = 1'b0; cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      end else if (trig_in_write && !trig_sent && dma_owns_bus && !dma_rw) begin
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = ~pg;
        trig_sent = 1;
      end else begin
        drive_idle();
      end
    end
    if (!done) timeout = 1;
  endtask

  // Reference: 256 read/write pairs in consecutive cycles, reads on even cycles,
  // reads walk {pg,00..FF}, writes go to $2004 carrying the byte just read.
  function automatic int seq_errors(input logic [7:0] pg);
    int e;
    logic [15:0] a;
    e = 0;
    if (log_rw.size() != 512) return 1000 + log_rw.size();
    for (int i = 0; i < 256; i++) begin
      a = {pg, 8'(i)};
      if (log_rw[2*i] !== 1'b1 || log_addr[2*i] !== a) e++;
      if (log_rw[2*i+1] !== 1'b0 || log_addr[2*i+1] !== 16'h2004 ||
          log_data[2*i+1] !== mem[a]) e++;
    end
    for (int i = 0; i < 512; i++)
      if (log_cyc[i] != log_cyc[0] + i) e++;
    if ((log_cyc[0] % 2) != 0) e++;
    return e;
  endfunction

  task automatic test_reset();
    int bad_own;
    int bad_rdy;
    @(negedge clock);
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (dma_owns_bus !== 1'b0) begin failures++; $display("FAIL reset_owns got=%b exp=0", dma_owns_bus); end
    checks++; if (dma_rw !== 1'b1) begin failures++; $display("FAIL reset_rw got=%b exp=1", dma_rw); end
    checks++; if (dma_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", dma_addr); end
    checks++; if (dma_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", dma_wdata); end
    // mid-transfer reset
    cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
    repeat (300) begin
      @(negedge clock);
      drive_idle();
    end
    checks++; if (dma_owns_bus !== 1'b1) begin failures++; $display("FAIL active_before_reset got=%b exp=1", dma_owns_bus); end
    nreset = 1'b1;
    repeat (3) @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL midreset_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (dma_rw !== 1'b1) begin failures++; $display("FAIL midreset_rw got=%b exp=1", dma_rw); end
    bad_own = 0; bad_rdy = 0;
    repeat (600) begin
      if (dma_owns_bus !== 1'b0) bad_own++;
      if (cpu_rdy !== 1'b1) bad_rdy++;
      drive_idle();
      @(negedge clock);
    end
    checks++; if (bad_own !== 0) begin failures++; $display("FAIL post_reset_dma_cycles got=%0d exp=0", bad_own); end
    checks++; if (bad_rdy !== 0) begin failures++; $display("FAIL post_reset_stall got=%0d exp=0", bad_rdy); end
  endtask

  task automatic test_alignment();
    int e;
    run_transfer(8'h02, 0, 1'b0, 1'b0);
    e = seq_errors(8'h02);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL align_odd_timeout got=%b exp=0", timeout); end
    checks++; if (e !== 0) begin failures++; $display("FAIL align_odd_seq errors=%0d exp=0", e); end
    checks++; if (stall_cnt !== 513) begin failures++; $display("FAIL align_odd_stall got=%0d exp=513", stall_cnt); end
    checks++; if (first_rd !== trig_cyc + 2) begin failures++; $display("FAIL align_odd_first_read got=%0d exp=%0d", first_rd, trig_cyc + 2); end
    run_transfer(8'h02, 0, 1'b1, 1'b0);
    e = seq_errors(8'h02);
    checks++; if (e !== 0) begin failures++; $display("FAIL align_even_seq errors=%0d exp=0", e); end
    checks++; if (stall_cnt !== 514) begin failures++; $display("FAIL align_even_stall got=%0d exp=514", stall_cnt); end
    checks++; if (first_rd !== trig_cyc + 3) begin failures++; $display("FAIL align_even_first_read got=%0d exp=%0d", first_rd, trig_cyc + 3); end
  endtask

  task automatic test_halt_deferred();
    int e;
    bit ev;
    logic [7:0] pg;
    for (int r = 0; r < 2; r++) begin
      ev = bit'(r);
      pg = 8'($urandom);
      run_transfer(pg, 2, ev, 1'b0);
      e = seq_errors(pg);
      checks++; if (e !== 0) begin failures++; $display("FAIL deferred_seq pg=%h errors=%0d exp=0", pg, e); end
      checks++; if (stall_cnt !== 2 + (ev ? 514 : 513)) begin failures++; $display("FAIL deferred_stall got=%0d exp=%0d", stall_cnt, 2 + (ev ? 514 : 513)); end
      checks++; if (first_rd !== trig_cyc + 3 + (ev ? 2 : 1)) begin failures++; $display("FAIL deferred_first_read got=%0d exp=%0d", first_rd, trig_cyc + 3 + (ev ? 2 : 1)); end
    end
  endtask

  task automatic test_page_ff();
    int e;
    int zero_hits;
    run_transfer(8'hFF, 0, bit'($urandom_range(0, 1)), 1'b0);
    e = seq_errors(8'hFF);
    zero_hits = 0;
    foreach (log_addr[i]) if (log_addr[i] == 16'h0000) zero_hits++;
    checks++; if (e !== 0) begin failures++; $display("FAIL page_ff_seq errors=%0d exp=0", e); end
    checks++; if (zero_hits !== 0) begin failures++; $display("FAIL page_ff_zero_access got=%0d exp=0", zero_hits); end
    checks++; if (cpu_rdy !== 1'b1 || dma_owns_bus !== 1'b0) begin failures++; $display("FAIL page_ff_return rdy=%b owns=%b exp rdy=1 owns=0", cpu_rdy, dma_owns_bus); end
  endtask

  task automatic test_non_trigger();
    int bad;
    logic [15:0] addrs [3];
    addrs[0] = 16'h4015; addrs[1] = 16'h4013; addrs[2] = 16'h2014;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (i > 0 && (cpu_rdy !== 1'b1 || dma_owns_bus !== 1'b0)) bad++;
      cpu_rw = 1'b0; cpu_addr = addrs[i % 3]; cpu_wdata = 8'($urandom);
      if (i % 4 == 3) begin cpu_rw = 1'b1; cpu_addr = 16'h4014; end
    end
    @(negedge clock);
    if (cpu_rdy !== 1'b1 || dma_owns_bus !== 1'b0) bad++;
    drive_idle();
    checks++; if (bad !== 0) begin failures++; $display("FAIL non_trigger_idle bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_trigger_in_write();
    int e;
    bit ev;
    logic [7:0] pg;
    pg = 8'($urandom);
    ev = bit'($urandom_range(0, 1));
    run_transfer(pg, 0, ev, 1'b1);
    e = seq_errors(pg);
    checks++; if (e !== 0) begin failures++; $display("FAIL retrigger_seq pg=%h errors=%0d exp=0", pg, e); end
    checks++; if (stall_cnt !== (ev ? 514 : 513)) begin failures++; $display("FAIL retrigger_stall got=%0d exp=%0d", stall_cnt, ev ? 514 : 513); end
  endtask

  task automatic test_random();
    int e;
    int w;
    bit ev;
    logic [7:0] pg;
    for (int r = 0; r < 4; r++) begin
      pg = 8'($urandom);
      w  = $urandom_range(0, 3);
      ev = bit'($urandom_range(0, 1));
      run_transfer(pg, w, ev, 1'b0);
      e = seq_errors(pg);
      checks++; if (e !== 0) begin failures++; $display("FAIL random_seq pg=%h w=%0d errors=%0d exp=0", pg, w, e); end
      checks++; if (stall_cnt !== w + (ev ? 514 : 513)) begin failures++; $display("FAIL random_stall got=%0d exp=%0d", stall_cnt, w + (ev ? 514 : 513)); end
      checks++; if (first_rd !== trig_cyc + 1 + w + (ev ? 2 : 1)) begin failures++; $display("FAIL random_first_read got=%0d exp=%0d", first_rd, trig_cyc + 1 + w + (ev ? 2 : 1)); end
    end
  endtask

  initial begin
    nreset = 1'b1;
    drive_idle();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    apply_reset(3);
    test_reset();
    test_alignment();
    test_halt_deferred();
    test_page_ff();
    test_non_trigger();
    test_trigger_in_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
